// File: rtl/riscv_checkpoint_monitor_if.sv
// Signal bundle between the checkpoint monitor and whatever drives it (core, cache, config host).
// Names are from the monitor's point of view: i_* flow into it, o_* flow out of it.
interface riscv_checkpoint_monitor_if #(
  parameter int DWIDTH = 32,
  parameter int IDX_W  = 5
);
  logic              i_cfg_we;
  logic [IDX_W-1:0]  i_cfg_idx;
  logic [DWIDTH-1:0] i_cfg_ninst;
  logic [DWIDTH-1:0] i_cfg_ans;
  logic [DWIDTH-1:0] i_cfg_mask;
  logic              i_cfg_valid;
  logic              i_start;
  logic [DWIDTH-1:0] i_num_inst;
  logic [DWIDTH-1:0] i_output_port;
  logic              i_halt;
  logic              i_hit_pulse;
  logic              i_miss_pulse;
  logic [1:0]        o_state;
  logic              o_done;
  logic [1:0]        o_fail_code;
  logic              o_fail_to;
  logic [IDX_W-1:0]  o_fail_idx;
  logic [DWIDTH-1:0] o_fail_val;
  logic [IDX_W-1:0]  o_pass_cnt;
  logic [DWIDTH-1:0] o_cycle_cnt;
  logic [DWIDTH-1:0] o_hit_cnt;
  logic [DWIDTH-1:0] o_miss_cnt;

  modport master (
    output i_cfg_we, i_cfg_idx, i_cfg_ninst, i_cfg_ans, i_cfg_mask, i_cfg_valid,
           i_start, i_num_inst, i_output_port, i_halt, i_hit_pulse, i_miss_pulse,
    input  o_state, o_done, o_fail_code, o_fail_to, o_fail_idx, o_fail_val,
           o_pass_cnt, o_cycle_cnt, o_hit_cnt, o_miss_cnt
  );

  modport slave (
    input  i_cfg_we, i_cfg_idx, i_cfg_ninst, i_cfg_ans, i_cfg_mask, i_cfg_valid,
           i_start, i_num_inst, i_output_port, i_halt, i_hit_pulse, i_miss_pulse,
    output o_state, o_done, o_fail_code, o_fail_to, o_fail_idx, o_fail_val,
           o_pass_cnt, o_cycle_cnt, o_hit_cnt, o_miss_cnt
  );
endinterface

// File: rtl/riscv_checkpoint_monitor.sv
// Programmable checkpoint checker: walks a table of (instruction count, expected output) pairs
// in order against the running core and reports PASS/FAIL with cause, plus cycle/cache counters.
module riscv_checkpoint_monitor #(
  parameter int NUM_TEST = 22,
  parameter int DWIDTH   = 32,
  parameter int IDX_W    = 5,
  parameter int TIMEOUT  = 1000000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  riscv_checkpoint_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  localparam logic [1:0]        FC_NONE     = 2'd0;
  localparam logic [1:0]        FC_MISMATCH = 2'd1;
  localparam logic [1:0]        FC_SKIPPED  = 2'd2;
  localparam logic [1:0]        FC_INCOMPL  = 2'd3;
  localparam logic [IDX_W-1:0]  NT_IDX      = IDX_W'(NUM_TEST);
  localparam bit                TO_EN       = (TIMEOUT != 0);
  localparam logic [DWIDTH-1:0] TO_LAST     = DWIDTH'(TIMEOUT - 1);

  function automatic logic [DWIDTH-1:0] sat_inc(input logic [DWIDTH-1:0] v, input logic en);
    return (en && (v != {DWIDTH{1'b1}})) ? v + DWIDTH'(1) : v;
  endfunction

  function automatic logic [IDX_W-1:0] sat_inc_idx(input logic [IDX_W-1:0] v);
    return (v != {IDX_W{1'b1}}) ? v + IDX_W'(1) : v;
  endfunction

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]  r_pass_cnt, w_pass_nxt;
  logic [DWIDTH-1:0] r_cycle_cnt, w_cyc_nxt;
  logic [DWIDTH-1:0] r_hit_cnt, w_hit_nxt;
  logic [DWIDTH-1:0] r_miss_cnt, w_miss_nxt;
  logic [1:0]        r_fail_code, w_code_nxt;
  logic              r_fail_to, w_to_nxt;
  logic [IDX_W-1:0]  r_fail_idx, w_fidx_nxt;
  logic [DWIDTH-1:0] r_fail_val, w_fval_nxt;
  logic              r_done;

  logic [NUM_TEST-1:0] r_valid;
  logic [DWIDTH-1:0]   r_ninst [NUM_TEST];
  logic [DWIDTH-1:0]   r_ans   [NUM_TEST];
  logic [DWIDTH-1:0]   r_mask  [NUM_TEST];

  logic              w_cfg_ok;
  logic              w_in_range;
  logic              w_cur_valid;
  logic [DWIDTH-1:0] w_cur_ninst;
  logic              w_cur_match;
  logic              w_later_valid;
  logic              w_pending;
  logic              w_eval_fail;

  assign w_cfg_ok   = bus.i_cfg_we && (r_state != S_RUN) && (bus.i_cfg_idx < NT_IDX);
  assign w_in_range = (r_ptr < NT_IDX);

  // Valid bits reset with the block so a reset always leaves an empty table.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= {NUM_TEST{1'b0}};
    end else begin
      for (int i = 0; i < NUM_TEST; i++) begin
        if (w_cfg_ok && (bus.i_cfg_idx == IDX_W'(i))) begin
          r_valid[i] <= bus.i_cfg_valid;
        end
      end
    end
  end

  // Entry payload is qualified by r_valid, so it needs no reset.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_TEST; i++) begin
      if (w_cfg_ok && (bus.i_cfg_idx == IDX_W'(i))) begin
        r_ninst[i] <= bus.i_cfg_ninst;
        r_ans[i]   <= bus.i_cfg_ans;
        r_mask[i]  <= bus.i_cfg_mask;
      end
    end
  end

  // Select the entry under the pointer and look for any valid entry beyond it.
  always_comb begin
    w_cur_valid   = 1'b0;
    w_cur_ninst   = {DWIDTH{1'b0}};
    w_cur_match   = 1'b0;
    w_later_valid = 1'b0;
    for (int i = 0; i < NUM_TEST; i++) begin
      if (r_ptr == IDX_W'(i)) begin
        w_cur_valid = r_valid[i];
        w_cur_ninst = r_ninst[i];
        w_cur_match = ((bus.i_output_port & r_mask[i]) == (r_ans[i] & r_mask[i]));
      end else if ((IDX_W'(i) > r_ptr) && r_valid[i]) begin
        w_later_valid = 1'b1;
      end else begin
        w_later_valid = w_later_valid;
      end
    end
  end

  // An entry still outstanding after this cycle's evaluation makes HALT an incomplete run.
  assign w_pending = (w_in_range && w_cur_valid &&
                      !((bus.i_num_inst == w_cur_ninst) && w_cur_match)) || w_later_valid;

  // Next-state and next-value logic for the run controller.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_pass_nxt  = r_pass_cnt;
    w_cyc_nxt   = r_cycle_cnt;
    w_hit_nxt   = r_hit_cnt;
    w_miss_nxt  = r_miss_cnt;
    w_code_nxt  = r_fail_code;
    w_to_nxt    = r_fail_to;
    w_fidx_nxt  = r_fail_idx;
    w_fval_nxt  = r_fail_val;
    w_eval_fail = 1'b0;
    case (r_state)
      S_RUN: begin
        w_cyc_nxt  = sat_inc(r_cycle_cnt, 1'b1);
        w_hit_nxt  = sat_inc(r_hit_cnt, bus.i_hit_pulse);
        w_miss_nxt = sat_inc(r_miss_cnt, bus.i_miss_pulse);
        if (!w_in_range) begin
          w_ptr_nxt = r_ptr;
        end else if (!w_cur_valid) begin
          w_ptr_nxt = r_ptr + IDX_W'(1);
        end else if (bus.i_num_inst == w_cur_ninst) begin
          if (w_cur_match) begin
            w_pass_nxt = sat_inc_idx(r_pass_cnt);
            w_ptr_nxt  = r_ptr + IDX_W'(1);
          end else begin
            w_eval_fail = 1'b1;
            w_code_nxt  = FC_MISMATCH;
          end
        end else if (bus.i_num_inst > w_cur_ninst) begin
          w_eval_fail = 1'b1;
          w_code_nxt  = FC_SKIPPED;
        end else begin
          w_ptr_nxt = r_ptr;
        end
        // Priority: entry failure, then HALT, then timeout.
        if (w_eval_fail) begin
          w_state_nxt = S_FAIL;
          w_to_nxt    = 1'b0;
          w_fidx_nxt  = r_ptr;
          w_fval_nxt  = bus.i_output_port;
        end else if (bus.i_halt) begin
          if (w_pending) begin
            w_state_nxt = S_FAIL;
            w_code_nxt  = FC_INCOMPL;
            w_to_nxt    = 1'b0;
            w_fidx_nxt  = r_ptr;
            w_fval_nxt  = bus.i_output_port;
          end else begin
            w_state_nxt = S_PASS;
          end
        end else if (TO_EN && (r_cycle_cnt == TO_LAST)) begin
          w_state_nxt = S_FAIL;
          w_code_nxt  = FC_INCOMPL;
          w_to_nxt    = 1'b1;
          w_fidx_nxt  = r_ptr;
          w_fval_nxt  = bus.i_output_port;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
    if (bus.i_start) begin
      w_state_nxt = S_RUN;
      w_ptr_nxt   = {IDX_W{1'b0}};
      w_pass_nxt  = {IDX_W{1'b0}};
      w_cyc_nxt   = {DWIDTH{1'b0}};
      w_hit_nxt   = {DWIDTH{1'b0}};
      w_miss_nxt  = {DWIDTH{1'b0}};
      w_code_nxt  = FC_NONE;
      w_to_nxt    = 1'b0;
      w_fidx_nxt  = {IDX_W{1'b0}};
      w_fval_nxt  = {DWIDTH{1'b0}};
    end else begin
      w_ptr_nxt = w_ptr_nxt;
    end
  end

  // State and result registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_done      <= 1'b0;
      r_ptr       <= {IDX_W{1'b0}};
      r_pass_cnt  <= {IDX_W{1'b0}};
      r_cycle_cnt <= {DWIDTH{1'b0}};
      r_hit_cnt   <= {DWIDTH{1'b0}};
      r_miss_cnt  <= {DWIDTH{1'b0}};
      r_fail_code <= FC_NONE;
      r_fail_to   <= 1'b0;
      r_fail_idx  <= {IDX_W{1'b0}};
      r_fail_val  <= {DWIDTH{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_done      <= (w_state_nxt == S_PASS) || (w_state_nxt == S_FAIL);
      r_ptr       <= w_ptr_nxt;
      r_pass_cnt  <= w_pass_nxt;
      r_cycle_cnt <= w_cyc_nxt;
      r_hit_cnt   <= w_hit_nxt;
      r_miss_cnt  <= w_miss_nxt;
      r_fail_code <= w_code_nxt;
      r_fail_to   <= w_to_nxt;
      r_fail_idx  <= w_fidx_nxt;
      r_fail_val  <= w_fval_nxt;
    end
  end

  assign bus.o_state     = r_state;
  assign bus.o_done      = r_done;
  assign bus.o_fail_code = r_fail_code;
  assign bus.o_fail_to   = r_fail_to;
  assign bus.o_fail_idx  = r_fail_idx;
  assign bus.o_fail_val  = r_fail_val;
  assign bus.o_pass_cnt  = r_pass_cnt;
  assign bus.o_cycle_cnt = r_cycle_cnt;
  assign bus.o_hit_cnt   = r_hit_cnt;
  assign bus.o_miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_riscv_checkpoint_monitor.sv
// Directed bench for riscv_checkpoint_monitor: table programming, pass/mismatch/skip/incomplete,
// timeout vs HALT, cache counters and asynchronous reset.
module tb_riscv_checkpoint_monitor;
  localparam int NT = 4;
  localparam int DW = 32;
  localparam int IW = 3;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  riscv_checkpoint_monitor_if #(.DWIDTH(DW), .IDX_W(IW)) bus ();

  riscv_checkpoint_monitor #(.NUM_TEST(NT), .DWIDTH(DW), .IDX_W(IW), .TIMEOUT(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [IW-1:0] idx, input logic [31:0] ninst, input logic [31:0] ans,
                     input logic [31:0] mask, input logic vld);
    bus.i_cfg_we    = 1'b1;
    bus.i_cfg_idx   = idx;
    bus.i_cfg_ninst = ninst;
    bus.i_cfg_ans   = ans;
    bus.i_cfg_mask  = mask;
    bus.i_cfg_valid = vld;
    step();
    bus.i_cfg_we    = 1'b0;
  endtask

  task automatic start_pulse();
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
  endtask

  task automatic drive(input logic [31:0] ninst, input logic [31:0] outp);
    bus.i_num_inst    = ninst;
    bus.i_output_port = outp;
    step();
  endtask

  initial begin
    bus.i_cfg_we = 1'b0; bus.i_cfg_idx = '0; bus.i_cfg_ninst = '0; bus.i_cfg_ans = '0;
    bus.i_cfg_mask = '0; bus.i_cfg_valid = 1'b0; bus.i_start = 1'b0; bus.i_num_inst = '0;
    bus.i_output_port = '0; bus.i_halt = 1'b0; bus.i_hit_pulse = 1'b0; bus.i_miss_pulse = 1'b0;
    step();
    step();
    chk("rst_state", bus.o_state, 32'd0);
    chk("rst_done", bus.o_done, 32'd0);
    chk("rst_cycle", bus.o_cycle_cnt, 32'd0);
    rst = 1'b0;

    // 1: three matching checkpoints then HALT
    cfg(3'd0, 32'd1, 32'd5, 32'hFFFF_FFFF, 1'b1);
    cfg(3'd1, 32'd2, 32'd0, 32'hFFFF_FFFF, 1'b1);
    cfg(3'd2, 32'd3, 32'd1, 32'hFFFF_FFFF, 1'b1);
    start_pulse();
    chk("t1_run", bus.o_state, 32'd1);
    drive(32'd0, 32'd0);
    drive(32'd1, 32'd5);
    drive(32'd2, 32'd0);
    drive(32'd3, 32'd1);
    bus.i_halt = 1'b1;
    step();
    bus.i_halt = 1'b0;
    chk("t1_state", bus.o_state, 32'd2);
    chk("t1_done", bus.o_done, 32'd1);
    chk("t1_pass", bus.o_pass_cnt, 32'd3);
    chk("t1_code", bus.o_fail_code, 32'd0);
    chk("t1_cycle", bus.o_cycle_cnt, 32'd5);

    // 2a: mismatch at entry 1
    start_pulse();
    drive(32'd1, 32'd5);
    drive(32'd2, 32'd7);
    chk("t2_state", bus.o_state, 32'd3);
    chk("t2_code", bus.o_fail_code, 32'd1);
    chk("t2_idx", bus.o_fail_idx, 32'd1);
    chk("t2_val", bus.o_fail_val, 32'd7);
    chk("t2_pass", bus.o_pass_cnt, 32'd1);
    chk("t2_to", bus.o_fail_to, 32'd0);

    // 2b: masked compare passes; a config write during RUN must be ignored
    cfg(3'd1, 32'd2, 32'd0, 32'hFFFF_FFF8, 1'b1);
    start_pulse();
    bus.i_cfg_we = 1'b1; bus.i_cfg_idx = 3'd2; bus.i_cfg_valid = 1'b0; bus.i_cfg_ninst = '0;
    drive(32'd0, 32'd0);
    bus.i_cfg_we = 1'b0;
    drive(32'd1, 32'd5);
    drive(32'd2, 32'd7);
    drive(32'd3, 32'd1);
    bus.i_halt = 1'b1;
    step();
    bus.i_halt = 1'b0;
    chk("t2b_state", bus.o_state, 32'd2);
    chk("t2b_pass", bus.o_pass_cnt, 32'd3);

    // 3a: checkpoint jumped over
    cfg(3'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    start_pulse();
    drive(32'd4, 32'd0);
    drive(32'd6, 32'd0);
    chk("t3_state", bus.o_state, 32'd3);
    chk("t3_code", bus.o_fail_code, 32'd2);
    chk("t3_idx", bus.o_fail_idx, 32'd0);

    // 3b: HALT with entries still outstanding
    cfg(3'd0, 32'd1, 32'd5, 32'hFFFF_FFFF, 1'b1);
    start_pulse();
    drive(32'd1, 32'd5);
    bus.i_halt = 1'b1;
    drive(32'd2, 32'd0);
    bus.i_halt = 1'b0;
    chk("t3b_state", bus.o_state, 32'd3);
    chk("t3b_code", bus.o_fail_code, 32'd3);
    chk("t3b_to", bus.o_fail_to, 32'd0);
    chk("t3b_idx", bus.o_fail_idx, 32'd1);
    chk("t3b_pass", bus.o_pass_cnt, 32'd2);

    // 4a: timeout after 20 RUN cycles
    bus.i_num_inst = 32'd0; bus.i_output_port = 32'd0;
    start_pulse();
    repeat (19) step();
    chk("t4_run19", bus.o_state, 32'd1);
    chk("t4_cyc19", bus.o_cycle_cnt, 32'd19);
    step();
    chk("t4_state", bus.o_state, 32'd3);
    chk("t4_code", bus.o_fail_code, 32'd3);
    chk("t4_to", bus.o_fail_to, 32'd1);
    chk("t4_cycle", bus.o_cycle_cnt, 32'd20);

    // 4b: HALT on the timeout cycle wins
    start_pulse();
    repeat (19) step();
    bus.i_halt = 1'b1;
    step();
    bus.i_halt = 1'b0;
    chk("t4b_state", bus.o_state, 32'd3);
    chk("t4b_to", bus.o_fail_to, 32'd0);
    chk("t4b_cycle", bus.o_cycle_cnt, 32'd20);

    // 6: asynchronous reset mid-run clears outputs and table
    start_pulse();
    step();
    step();
    chk("t6_run", bus.o_state, 32'd1);
    chk("t6_cyc", bus.o_cycle_cnt, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_state", bus.o_state, 32'd0);
    chk("t6_rst_cycle", bus.o_cycle_cnt, 32'd0);
    chk("t6_rst_pass", bus.o_pass_cnt, 32'd0);
    step();
    rst = 1'b0;
    bus.i_hit_pulse = 1'b1; bus.i_miss_pulse = 1'b1;
    repeat (3) step();
    chk("t5_idle_hit", bus.o_hit_cnt, 32'd0);
    bus.i_hit_pulse = 1'b0; bus.i_miss_pulse = 1'b0;
    start_pulse();
    bus.i_halt = 1'b1;
    step();
    bus.i_halt = 1'b0;
    chk("t6_pass", bus.o_state, 32'd2);
    chk("t6_code", bus.o_fail_code, 32'd0);

    // 5: simultaneous hit/miss pulses for 10 RUN cycles
    bus.i_hit_pulse = 1'b1; bus.i_miss_pulse = 1'b1;
    start_pulse();
    repeat (9) step();
    bus.i_halt = 1'b1;
    step();
    bus.i_halt = 1'b0;
    chk("t5_state", bus.o_state, 32'd2);
    chk("t5_hit", bus.o_hit_cnt, 32'd10);
    chk("t5_miss", bus.o_miss_cnt, 32'd10);
    chk("t5_cycle", bus.o_cycle_cnt, 32'd10);
    repeat (2) step();
    chk("t5_hold_hit", bus.o_hit_cnt, 32'd10);
    bus.i_hit_pulse = 1'b0; bus.i_miss_pulse = 1'b0;
    start_pulse();
    chk("t5_clr_hit", bus.o_hit_cnt, 32'd0);
    chk("t5_clr_miss", bus.o_miss_cnt, 32'd0);
    chk("t5_clr_state", bus.o_state, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
